// File: rtl/cmpl_rr_arbiter.sv
// cmpl_rr_arbiter: round-robin arbiter that moves one engine return word per
// grant into a one-entry output register. The register is drained toward the
// completion block with a valid/ready handshake and a running completion
// count is kept. A simultaneous drain and load sustains one word per cycle.
module cmpl_rr_arbiter #(
    parameter  int KERNEL_NUM   = 2,
    parameter  int RETURN_WIDTH = 41,
    parameter  int CNT_WIDTH    = 32,
    localparam int IDX_W        = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             arb_enable_i,
    input  logic [KERNEL_NUM-1:0]            complete_ready_i,
    input  logic [RETURN_WIDTH*KERNEL_NUM-1:0] complete_data_i,
    output logic [KERNEL_NUM-1:0]            complete_accept_o,
    output logic                             push_o,
    output logic [RETURN_WIDTH-1:0]          push_data_o,
    input  logic                             sink_ready_i,
    output logic [IDX_W-1:0]                 grant_idx_o,
    output logic [CNT_WIDTH-1:0]             cmpl_count_o,
    output logic                             busy_o
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_found;
    logic [RETURN_WIDTH-1:0] win_word;
    logic                    drain;
    logic                    load;

    assign push_o = (state == FULL);
    assign drain  = push_o && sink_ready_i;
    assign load   = !rst && arb_enable_i && (!push_o || drain) && win_found;
    assign busy_o = push_o || (|complete_ready_i);

    // Pick the first requester after the last granted engine, wrapping around.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= KERNEL_NUM; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % KERNEL_NUM);
            if (!win_found && complete_ready_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winning engine's return word.
    always_comb begin
        win_word = '0;
        for (int unsigned k = 0; k < KERNEL_NUM; k++) begin
            if (IDX_W'(k) == win_idx) begin
                win_word = complete_data_i[k*RETURN_WIDTH +: RETURN_WIDTH];
            end
        end
    end

    // One-hot accept strobe to the granted engine in the load cycle.
    always_comb begin
        complete_accept_o = '0;
        if (load) begin
            complete_accept_o[win_idx] = 1'b1;
        end
    end

    // Output register, round-robin pointer and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            push_data_o  <= '0;
            grant_idx_o  <= '0;
            cmpl_count_o <= '0;
            rr_ptr       <= IDX_W'(KERNEL_NUM - 1);
        end else begin
            if (load) begin
                state       <= FULL;
                push_data_o <= win_word;
                grant_idx_o <= win_idx;
                rr_ptr      <= win_idx;
            end else if (drain) begin
                state <= EMPTY;
            end
            if (drain) begin
                cmpl_count_o <= cmpl_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmpl_rr_arbiter.sv
// Testbench for cmpl_rr_arbiter with four engines. A second instance with a
// 4-bit counter shares all stimulus so counter wrap can be observed.
module tb_cmpl_rr_arbiter;

    localparam int K  = 4;
    localparam int RW = 41;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic [K-1:0]    req = '0;
    logic [RW*K-1:0] data = '0;
    logic            sink = 1'b0;

    logic [K-1:0]    acc, acc_w;
    logic            push, push_w, busy, busy_w;
    logic [RW-1:0]   pdata, pdata_w;
    logic [1:0]      gidx, gidx_w;
    logic [31:0]     cnt;
    logic [3:0]      cnt_w;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic            m_full;
    logic [RW-1:0]   m_data;
    int              m_idx;
    int              m_last;
    int unsigned     m_cnt;

    cmpl_rr_arbiter #(.KERNEL_NUM(K), .RETURN_WIDTH(RW), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .arb_enable_i(en), .complete_ready_i(req),
        .complete_data_i(data), .complete_accept_o(acc), .push_o(push),
        .push_data_o(pdata), .sink_ready_i(sink), .grant_idx_o(gidx),
        .cmpl_count_o(cnt), .busy_o(busy)
    );

    cmpl_rr_arbiter #(.KERNEL_NUM(K), .RETURN_WIDTH(RW), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .arb_enable_i(en), .complete_ready_i(req),
        .complete_data_i(data), .complete_accept_o(acc_w), .push_o(push_w),
        .push_data_o(pdata_w), .sink_ready_i(sink), .grant_idx_o(gidx_w),
        .cmpl_count_o(cnt_w), .busy_o(busy_w)
    );

    always #5 clk = ~clk;

    // Winner the rules predict for the current inputs, -1 if none.
    function automatic int exp_winner();
        int w = -1;
        if (!rst && en && (!m_full || sink)) begin
            for (int i = 1; i <= K; i++) begin
                int k = (m_last + i) % K;
                if (w < 0 && req[k]) w = k;
            end
        end
        return w;
    endfunction

    function automatic logic [K-1:0] exp_accept();
        int w = exp_winner();
        logic [K-1:0] a = '0;
        if (w >= 0) a[w] = 1'b1;
        return a;
    endfunction

    // Advance one clock edge and update the reference model.
    task automatic tick();
        int w;
        logic dr;
        logic [RW-1:0] word;
        w = exp_winner();
        dr = m_full && sink;
        word = (w >= 0) ? data[w*RW +: RW] : '0;
        @(posedge clk);
        if (rst) begin
            m_full = 1'b0; m_data = '0; m_idx = 0; m_last = K - 1; m_cnt = 0;
        end else begin
            if (dr) m_cnt++;
            if (w >= 0) begin
                m_full = 1'b1; m_data = word; m_idx = w; m_last = w;
            end else if (dr) begin
                m_full = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; en = 1'b1; sink = 1'b1;
        #1;
        n_cmp++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL reset_no_accept: got %b expected 0000", acc); end
        tick();
        rst = 1'b0; req = '0;
        #1;
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b expected 0", push); end
        n_cmp++; if (pdata !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", pdata); end
        n_cmp++; if (gidx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", gidx); end
        n_cmp++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        req = 4'b0100; sink = 1'b1;
        data[2*RW +: RW] = 41'h0_0000_00AB;
        #1;
        n_cmp++; if (acc !== 4'b0100) begin n_fail++; $display("FAIL single_accept: got %b expected 0100", acc); end
        tick();
        req = '0;
        #1;
        n_cmp++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL single_accept_1cyc: got %b expected 0000", acc); end
        n_cmp++; if (push !== 1'b1) begin n_fail++; $display("FAIL single_push: got %b expected 1", push); end
        n_cmp++; if (pdata !== 41'hAB) begin n_fail++; $display("FAIL single_data: got %h expected ab", pdata); end
        n_cmp++; if (gidx !== 2'd2) begin n_fail++; $display("FAIL single_idx: got %0d expected 2", gidx); end
        tick();
        n_cmp++; if (cnt !== 32'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", cnt); end
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", push); end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] ew;
        do_reset();
        req = '1; sink = 1'b1; en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < K; k++) data[k*RW +: RW] = 41'(k*256 + c);
            #1;
            n_cmp++; if (acc !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL b2b_accept[%0d]: got %b expected %b", c, acc, 4'(1 << (c % 4))); end
            if (c > 0) begin
                ew = 41'(((c - 1) % 4) * 256 + c - 1);
                n_cmp++; if (push !== 1'b1) begin n_fail++; $display("FAIL b2b_push[%0d]: got %b expected 1", c, push); end
                n_cmp++; if (gidx !== 2'((c - 1) % 4)) begin n_fail++; $display("FAIL b2b_idx[%0d]: got %0d expected %0d", c, gidx, (c - 1) % 4); end
                n_cmp++; if (pdata !== ew) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", c, pdata, ew); end
                n_cmp++; if (cnt !== 32'(c - 1)) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", c, cnt, c - 1); end
            end
            tick();
        end
        req = '0;
        tick();
        n_cmp++; if (cnt !== 32'd8) begin n_fail++; $display("FAIL b2b_cnt8: got %0d expected 8", cnt); end
        n_cmp++; if (cnt_w !== 4'd8) begin n_fail++; $display("FAIL b2b_cnt8_w: got %0d expected 8", cnt_w); end
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", push); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010; sink = 1'b0; en = 1'b1;
        data[1*RW +: RW] = 41'h111;
        #1;
        n_cmp++; if (acc !== 4'b0010) begin n_fail++; $display("FAIL bp_first_accept: got %b expected 0010", acc); end
        tick();
        req = 4'b1001;
        data[0 +: RW] = 41'h100;
        data[3*RW +: RW] = 41'h333;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL bp_accept[%0d]: got %b expected 0000", c, acc); end
            n_cmp++; if (push !== 1'b1) begin n_fail++; $display("FAIL bp_push[%0d]: got %b expected 1", c, push); end
            n_cmp++; if (pdata !== 41'h111) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected 111", c, pdata); end
            n_cmp++; if (gidx !== 2'd1) begin n_fail++; $display("FAIL bp_idx[%0d]: got %0d expected 1", c, gidx); end
            tick();
        end
        sink = 1'b1;
        #1;
        n_cmp++; if (acc !== 4'b1000) begin n_fail++; $display("FAIL bp_release_accept: got %b expected 1000", acc); end
        tick();
        n_cmp++; if (push !== 1'b1) begin n_fail++; $display("FAIL bp_release_push: got %b expected 1", push); end
        n_cmp++; if (gidx !== 2'd3) begin n_fail++; $display("FAIL bp_release_idx: got %0d expected 3", gidx); end
        n_cmp++; if (pdata !== 41'h333) begin n_fail++; $display("FAIL bp_release_data: got %h expected 333", pdata); end
        n_cmp++; if (cnt !== 32'd1) begin n_fail++; $display("FAIL bp_release_cnt: got %0d expected 1", cnt); end
    endtask

    task automatic test_enable();
        en = 1'b0; sink = 1'b1; req = 4'b0001;
        #1;
        n_cmp++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL en_off_accept: got %b expected 0000", acc); end
        tick();
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL en_off_drain: got %b expected 0", push); end
        n_cmp++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL en_off_accept2: got %b expected 0000", acc); end
        n_cmp++; if (cnt !== 32'd2) begin n_fail++; $display("FAIL en_off_cnt: got %0d expected 2", cnt); end
        en = 1'b1;
        #1;
        n_cmp++; if (acc !== 4'b0001) begin n_fail++; $display("FAIL en_on_accept: got %b expected 0001", acc); end
        tick();
        req = '0;
        n_cmp++; if (gidx !== 2'd0) begin n_fail++; $display("FAIL en_on_idx: got %0d expected 0", gidx); end
        tick();
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        req = 4'b0001; sink = 1'b1; en = 1'b1;
        tick();
        for (int n = 1; n <= 17; n++) begin
            data[0 +: RW] = 41'(n);
            tick();
            n_cmp++; if (cnt_w !== 4'(n % 16)) begin n_fail++; $display("FAIL wrap_cnt_w[%0d]: got %0d expected %0d", n, cnt_w, n % 16); end
            n_cmp++; if (cnt !== 32'(n)) begin n_fail++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", n, cnt, n); end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; req = '1;
        #1;
        n_cmp++; if (push !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_full: got %b expected 1", push); end
        n_cmp++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL rmid_accept_in_rst: got %b expected 0000", acc); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL rmid_push: got %b expected 0", push); end
        n_cmp++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d expected 0", cnt); end
        n_cmp++; if (acc !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_grant: got %b expected 0001", acc); end
        tick();
        n_cmp++; if (gidx !== 2'd0) begin n_fail++; $display("FAIL rmid_idx: got %0d expected 0", gidx); end
    endtask

    task automatic test_random();
        logic [K-1:0] ea;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req  = 4'($urandom);
            sink = ($urandom_range(0, 9) < 7);
            en   = ($urandom_range(0, 19) < 17);
            rst  = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < K; k++) data[k*RW +: RW] = 41'({$urandom, $urandom});
            #1;
            ea = exp_accept();
            n_cmp++; if (acc !== ea) begin n_fail++; $display("FAIL rnd_accept[%0d]: got %b expected %b", c, acc, ea); end
            n_cmp++; if (push !== m_full) begin n_fail++; $display("FAIL rnd_push[%0d]: got %b expected %b", c, push, m_full); end
            n_cmp++; if (pdata !== m_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, pdata, m_data); end
            n_cmp++; if (gidx !== 2'(m_idx)) begin n_fail++; $display("FAIL rnd_idx[%0d]: got %0d expected %0d", c, gidx, m_idx); end
            n_cmp++; if (cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", c, cnt, m_cnt); end
            n_cmp++; if (cnt_w !== 4'(m_cnt % 16)) begin n_fail++; $display("FAIL rnd_cnt_w[%0d]: got %0d expected %0d", c, cnt_w, m_cnt % 16); end
            n_cmp++; if (busy !== (m_full || (|req))) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, busy, m_full || (|req)); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        m_full = 1'b0; m_data = '0; m_idx = 0; m_last = K - 1; m_cnt = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_enable();
        test_cnt_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmpl_rr_arbiter.md
Name: cmpl_rr_arbiter

Overview:
- Round-robin arbiter between KERNEL_NUM engine completion ports and the single completion push port of the job completion block.
- Accepts one engine's RETURN_WIDTH return word per grant and holds it in a one-entry output register.
- Forwards the held word with a valid/ready handshake, keeps a running completion count, and sustains one completion per cycle when the sink is always ready.

Parameters:
- KERNEL_NUM, 2, number of engine completion requesters (1..16)
- RETURN_WIDTH, 41, width of one engine return word
- CNT_WIDTH, 32, width of the completion counter
- IDX_W, derived: clog2(KERNEL_NUM) when KERNEL_NUM>1, else 1; not overridable

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- arb_enable_i  in  1  1 = new grants allowed; 0 = no new grants, but the held word still drains
- complete_ready_i  in  KERNEL_NUM  per-engine level request; engine k has a return word pending
- complete_data_i  in  RETURN_WIDTH*KERNEL_NUM  engine k word on bits [k*RETURN_WIDTH +: RETURN_WIDTH]
- complete_accept_o  out  KERNEL_NUM  one-hot, single-cycle accept of the granted engine's word (combinational)
- push_o  out  1  held word valid toward the completion block
- push_data_o  out  RETURN_WIDTH  held return word
- sink_ready_i  in  1  completion block can take a word
- grant_idx_o  out  IDX_W  index of the engine whose word is currently held
- cmpl_count_o  out  CNT_WIDTH  total words transferred to the sink
- busy_o  out  1  push_o OR any complete_ready_i bit

Behaviour:
- Reset values (rst=1 at an edge): push_o=0, push_data_o=0, grant_idx_o=0, cmpl_count_o=0, rr_ptr=KERNEL_NUM-1 (so engine 0 wins first).
- Reset mid-operation discards the held word; no accept pulse is issued while rst=1.
- State machine has two states:
  - EMPTY: push_o=0
  - FULL: push_o=1
- Terms:
  - drain = push_o AND sink_ready_i
  - can_load = arb_enable_i AND (EMPTY OR drain)
- Grant selection (combinational):
  - Search complete_ready_i starting at index (rr_ptr+1) mod KERNEL_NUM, ascending with wrap.
  - The first set bit is the winner g.
  - No set bit means no grant.
- Load:
  - Condition: can_load AND a winner exists.
  - Same cycle: complete_accept_o[g]=1 and all other accept bits are 0.
  - Next edge: push_data_o <= word g, grant_idx_o <= g, rr_ptr <= g, state becomes FULL.
- Latency: accept cycle N, push_o=1 from cycle N+1.
- Drain without load: next edge, state becomes EMPTY; push_data_o and grant_idx_o keep their last values.
- Simultaneous drain and load: the held word leaves and the new word enters on the same edge; state stays FULL. This gives back-to-back throughput of 1 word per cycle.
- FULL with sink_ready_i=0:
  - Hold push_o, push_data_o and grant_idx_o stable.
  - No accept pulses.
- arb_enable_i=0:
  - No accept pulses.
  - A FULL word still drains normally.
  - rr_ptr is unchanged.
- Engine contract: after an accept at edge N, complete_ready_i[k] shows the engine's next status from cycle N+1. The arbiter does not mask engines after a grant.
- Counter: cmpl_count_o increments by 1 on every drain edge. It wraps from 2^CNT_WIDTH-1 to 0 without any flag.
- KERNEL_NUM=1: the arbiter degenerates to a pass-through register. grant_idx_o=0 always; the rr logic must still elaborate.
- Requests that drop before being granted are simply not serviced. No error is raised.
- complete_data_i is sampled only on the load edge; data on unaccepted engines is don't-care.

Test Plan (KERNEL_NUM=4, RETURN_WIDTH=41 unless stated):
- Reset, then engine 2 requests alone with data 41'h0_0000_00AB, sink_ready_i=1:
  - accept_o=4'b0100 for 1 cycle
  - next cycle push_o=1, push_data_o=41'hAB, grant_idx_o=2
  - cmpl_count_o=1 after the drain
- All 4 engines request continuously (each re-presents its data after accept), sink_ready_i=1:
  - grant order 0,1,2,3,0,...
  - one push per cycle
  - after 8 drains cmpl_count_o=8
- Back-pressure:
  - FULL with engine 1's word, sink_ready_i=0 for 5 cycles, engines 0 and 3 requesting: push_data_o stable and accept_o=0 throughout.
  - When sink_ready_i rises: same-cycle drain plus accept of engine 3 (rr_ptr=1 so search starts at 2, first request found is 3).
- arb_enable_i=0 while FULL and sink_ready_i=1, engine 0 requesting:
  - the word drains, state goes EMPTY, no accept
  - enable=1 -> accept_o=4'b0001 the next cycle
- Counter wrap with CNT_WIDTH=4: 17 drains -> cmpl_count_o reads 15 after drain 15, 0 after drain 16, 1 after drain 17.
- rst=1 asserted for one cycle while FULL:
  - push_o=0, cmpl_count_o=0 the following cycle
  - the next grant goes to the lowest requesting index (engine 0 when all request)
